modexp_loader: RTL and testbench



---
 rtl/modexp_pkg.sv | 35 +++
 rtl/modexp_loader_if.sv | 21 ++
 rtl/modexp_word_buf.sv | 21 ++
 rtl/modexp_loader.sv | 212 +++++++++++++++++++++
 tb/tb_modexp_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/modexp_pkg.sv
// Shared types and constants for the modexp operand loader.
package modexp_pkg;

    localparam int W     = 128;
    localparam int WORDS = 32;
    localparam int NP_W  = 64;
    localparam int AW    = $clog2(WORDS);
    localparam int CW    = $clog2(WORDS + 1);

    localparam logic [4:0] EXP_COMPUTE_DONE = 5'd13;
    localparam logic [4:0] EXP_RES_WORD     = 5'd14;
    localparam logic [4:0] EXP_RES_DONE     = 5'd15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_BURST,
        S_NP_FILL,
        S_NP_SEND,
        S_COMPUTE,
        S_RESULT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_E,
        PH_N,
        PH_R,
        PH_T,
        PH_NP,
        PH_M
    } phase_t;

endpackage

// File: rtl/modexp_loader_if.sv
// Host-side word stream into the loader and result stream back to the host.
interface modexp_loader_if;

    logic                   in_valid;
    logic                   in_ready;
    logic [modexp_pkg::W-1:0] in_data;
    logic                   res_valid;
    logic [modexp_pkg::W-1:0] res_data;
    logic                   res_last;

    modport master (
        output in_valid, in_data,
        input  in_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, res_valid, res_data, res_last
    );

endinterface

// File: rtl/modexp_word_buf.sv
// WORDS x W staging buffer: synchronous write, combinational read.
module modexp_word_buf
    import modexp_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/modexp_loader.sv
// Buffers host operand phases and replays them as gapless bursts to the modexp core.
// Optional watchdog on COMPUTE/RESULT: define MODEXP_LOADER_WATCHDOG_EN.
module modexp_loader
    import modexp_pkg::*;
`ifdef MODEXP_LOADER_WATCHDOG_EN
#(
    parameter int unsigned TO_CYCLES = 32'd16777216
)
`endif
(
    input  logic            clk,
    input  logic            reset,
    modexp_loader_if.slave  host,
    output logic            startInput,
    output logic [W-1:0]    e_buf,
    output logic [W-1:0]    n_buf,
    output logic [W-1:0]    r_buf,
    output logic [W-1:0]    t_buf,
    output logic [W-1:0]    m_buf,
    output logic [NP_W-1:0] nprime0_buf,
    output logic            startCompute,
    output logic            getResult,
    input  logic [4:0]      exp_state,
    input  logic [W-1:0]    res_out,
    output logic            busy,
    output logic            err
);

    state_t        state;
    phase_t        phase;
    logic [CW-1:0] wr_cnt;
    logic [AW-1:0] burst_cnt;
    logic [CW-1:0] res_cnt;
    logic          np_sent;

    logic          accept;
    logic          load_en;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [W-1:0]  rdata;

    always_comb begin
        host.in_ready = 1'b0;
        case (state)
            S_IDLE, S_NP_FILL: host.in_ready = 1'b1;
            S_FILL:            host.in_ready = (wr_cnt < CW'(WORDS));
            default:           host.in_ready = 1'b0;
        endcase
    end

    assign accept = host.in_valid & host.in_ready;
    assign waddr  = (state == S_FILL) ? wr_cnt[AW-1:0] : '0;
    // Read runs one word ahead of the output registers so each burst word lands on its own cycle.
    assign raddr   = (state == S_BURST) ? burst_cnt + AW'(1) : '0;
    assign load_en = ((state == S_GAP) && (phase != PH_NP)) ||
                     ((state == S_BURST) && (burst_cnt != AW'(WORDS - 1)));

    modexp_word_buf u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr),
        .wdata (host.in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            e_buf       <= '0;
            n_buf       <= '0;
            r_buf       <= '0;
            t_buf       <= '0;
            m_buf       <= '0;
            nprime0_buf <= '0;
        end else begin
            if (load_en) begin
                case (phase)
                    PH_E:    e_buf <= rdata;
                    PH_N:    n_buf <= rdata;
                    PH_R:    r_buf <= rdata;
                    PH_T:    t_buf <= rdata;
                    PH_M:    m_buf <= rdata;
                    default: ;
                endcase
            end
            if ((state == S_GAP) && (phase == PH_NP) && !np_sent)
                nprime0_buf <= rdata[NP_W-1:0];
        end
    end

`ifdef MODEXP_LOADER_WATCHDOG_EN
    logic [31:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            phase          <= PH_E;
            wr_cnt         <= '0;
            burst_cnt      <= '0;
            res_cnt        <= '0;
            np_sent        <= 1'b0;
            startInput     <= 1'b0;
            startCompute   <= 1'b0;
            getResult      <= 1'b0;
            busy           <= 1'b0;
            host.res_valid <= 1'b0;
            host.res_data  <= '0;
            host.res_last  <= 1'b0;
`ifdef MODEXP_LOADER_WATCHDOG_EN
            wd_cnt         <= '0;
            err            <= 1'b0;
`endif
        end else begin
            host.res_valid <= 1'b0;
            host.res_last  <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    state  <= S_FILL;
                    phase  <= PH_E;
                    wr_cnt <= CW'(1);
                    busy   <= 1'b1;
`ifdef MODEXP_LOADER_WATCHDOG_EN
                    err    <= 1'b0;
`endif
                end
                S_FILL: if (accept) begin
                    wr_cnt <= wr_cnt + CW'(1);
                    if (wr_cnt == CW'(WORDS - 1)) begin
                        state <= S_GAP;
                        if (phase == PH_E) startInput <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (phase != PH_NP) begin
                        state     <= S_BURST;
                        burst_cnt <= '0;
                    end else if (!np_sent) begin
                        state <= S_NP_SEND;
                    end else begin
                        state   <= S_FILL;
                        phase   <= PH_M;
                        wr_cnt  <= '0;
                        np_sent <= 1'b0;
                    end
                end
                S_BURST: begin
                    burst_cnt <= burst_cnt + AW'(1);
                    if (burst_cnt == AW'(WORDS - 1)) begin
                        case (phase)
                            PH_E: begin phase <= PH_N; state <= S_FILL; wr_cnt <= '0; end
                            PH_N: begin phase <= PH_R; state <= S_FILL; wr_cnt <= '0; end
                            PH_R: begin phase <= PH_T; state <= S_FILL; wr_cnt <= '0; end
                            PH_T: begin phase <= PH_NP; state <= S_NP_FILL; end
                            default: begin
                                state        <= S_COMPUTE;
                                startCompute <= 1'b1;
                                startInput   <= 1'b0;
                            end
                        endcase
                    end
                end
                S_NP_FILL: if (accept) state <= S_GAP;
                S_NP_SEND: begin
                    np_sent <= 1'b1;
                    state   <= S_GAP;
                end
                // Any result-word code seen here is ignored; only compute-done moves on.
                S_COMPUTE: if (exp_state == EXP_COMPUTE_DONE) begin
                    startCompute <= 1'b0;
                    getResult    <= 1'b1;
                    res_cnt      <= '0;
                    state        <= S_RESULT;
                end
                S_RESULT: begin
                    if (exp_state == EXP_RES_WORD) begin
                        host.res_valid <= 1'b1;
                        host.res_data  <= res_out;
                        host.res_last  <= (res_cnt == CW'(WORDS - 1));
                        res_cnt        <= res_cnt + CW'(1);
                    end else if (exp_state == EXP_RES_DONE) begin
                        getResult <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`ifdef MODEXP_LOADER_WATCHDOG_EN
            if ((state == S_COMPUTE) || (state == S_RESULT)) begin
                if (wd_cnt == TO_CYCLES - 1) begin
                    err          <= 1'b1;
                    startCompute <= 1'b0;
                    getResult    <= 1'b0;
                    state        <= S_DONE;
                    wd_cnt       <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 32'd1;
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_modexp_loader.sv
// Directed bench: operand fill/burst timing, result handoff tables, early finish, reset mid-burst.
module tb_modexp_loader;
    import modexp_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            startInput;
    logic [W-1:0]    e_buf, n_buf, r_buf, t_buf, m_buf;
    logic [NP_W-1:0] nprime0_buf;
    logic            startCompute, getResult;
    logic [4:0]      exp_state;
    logic [W-1:0]    res_out;
    logic            busy, err;

    modexp_loader_if hif();

    modexp_loader dut (
        .clk          (clk),
        .reset        (reset),
        .host         (hif),
        .startInput   (startInput),
        .e_buf        (e_buf),
        .n_buf        (n_buf),
        .r_buf        (r_buf),
        .t_buf        (t_buf),
        .m_buf        (m_buf),
        .nprime0_buf  (nprime0_buf),
        .startCompute (startCompute),
        .getResult    (getResult),
        .exp_state    (exp_state),
        .res_out      (res_out),
        .busy         (busy),
        .err          (err)
    );

    initial forever #5 clk = ~clk;

    localparam logic [NP_W-1:0] NP_VAL = 64'h3bea2df6a3b18a91;

    typedef struct {
        logic [4:0]   es;
        logic [W-1:0] ro;
        logic         sc, gr, rv, rl, bz, rdy;
    } vec_t;

    vec_t            tbl[$];
    int              full_hi;
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [W-1:0]    held [6];
    logic [NP_W-1:0] held_np;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gen(input int ph, input int k);
        if (ph == 0) return (k == 0) ? 128'h5 : 128'h0;
        return {32'(ph), 32'(k), 32'hA5A5_0000 ^ 32'(k), 32'(ph * 1000 + k)};
    endfunction

    function automatic logic [W-1:0] cur_out(input int ph);
        case (ph)
            0: return e_buf;
            1: return n_buf;
            2: return r_buf;
            3: return t_buf;
            default: return m_buf;
        endcase
    endfunction

    task automatic add_row(input logic [4:0] es, input logic [W-1:0] ro,
                           input logic sc, input logic gr, input logic rv,
                           input logic rl, input logic bz, input logic rdy);
        vec_t v;
        v.es = es; v.ro = ro; v.sc = sc; v.gr = gr;
        v.rv = rv; v.rl = rl; v.bz = bz; v.rdy = rdy;
        tbl.push_back(v);
    endtask

    task automatic clear_held();
        for (int i = 0; i < 6; i++) held[i] = '0;
        held_np = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"}, hif.in_ready, 1);
        chk({tag, ".startInput"}, startInput, 0);
        chk({tag, ".e_buf"}, e_buf, 0);
        chk({tag, ".n_buf"}, n_buf, 0);
        chk({tag, ".r_buf"}, r_buf, 0);
        chk({tag, ".t_buf"}, t_buf, 0);
        chk({tag, ".m_buf"}, m_buf, 0);
        chk({tag, ".nprime0_buf"}, nprime0_buf, 0);
        chk({tag, ".startCompute"}, startCompute, 0);
        chk({tag, ".getResult"}, getResult, 0);
        chk({tag, ".res_valid"}, hif.res_valid, 0);
        chk({tag, ".res_data"}, hif.res_data, 0);
        chk({tag, ".res_last"}, hif.res_last, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".err"}, err, 0);
    endtask

    // Offer one word at a negedge and return at the negedge after it is accepted.
    task automatic send_word(input logic [W-1:0] d, input bit stall);
        int s = 0;
        int guard = 0;
        while (stall && s < 4 && $urandom_range(0, 1) == 1) begin
            hif.in_valid = 1'b0;
            @(negedge clk);
            s++;
        end
        hif.in_valid = 1'b1;
        hif.in_data  = d;
        while (hif.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("send_word.ready_timeout", 0, 1);
        @(negedge clk);
        hif.in_valid = 1'b0;
    endtask

    task automatic fill_and_burst(input int ph, input bit stall, input bit junk,
                                  input int abort_k, output bit aborted);
        aborted = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            send_word(gen(ph, k), stall);
            if (ph == 0 && k == 0) begin
                chk("busy_rise", busy, 1);
                chk("startInput_low_in_fill", startInput, 0);
            end
        end
        chk($sformatf("gap%0d.in_ready", ph), hif.in_ready, 0);
        chk($sformatf("gap%0d.startInput", ph), startInput, 1);
        chk($sformatf("gap%0d.hold", ph), cur_out(ph), held[ph]);
        if (junk) begin
            hif.in_valid = 1'b1;
            hif.in_data  = 128'hDEAD_BEEF;
        end
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            chk($sformatf("burst%0d[%0d]", ph, k), cur_out(ph), gen(ph, k));
            if (junk) chk($sformatf("burst%0d[%0d].in_ready", ph, k), hif.in_ready, 0);
            if (k == abort_k) begin
                aborted = 1'b1;
                hif.in_valid = 1'b0;
                return;
            end
            if (k == WORDS - 1) hif.in_valid = 1'b0;
        end
        held[ph] = gen(ph, WORDS - 1);
    endtask

    task automatic np_phase(input bit stall);
        send_word({64'hFFFF_FFFF_FFFF_FFFF, NP_VAL}, stall);
        chk("np_gap.in_ready", hif.in_ready, 0);
        chk("np_gap.hold", nprime0_buf, held_np);
        @(negedge clk);
        chk("np_send.value", nprime0_buf, NP_VAL);
        chk("np_send.in_ready", hif.in_ready, 0);
        @(negedge clk);
        chk("np_post_gap.hold", nprime0_buf, NP_VAL);
        held_np = NP_VAL;
    endtask

    task automatic run_job(input bit stall, input bit junk, input int ab_ph,
                           input int ab_k, output bit aborted);
        aborted = 1'b0;
        for (int p = 0; p < 4; p++) begin
            fill_and_burst(p, stall, junk && (p == 0), (p == ab_ph) ? ab_k : -1, aborted);
            if (aborted) return;
        end
        np_phase(stall);
        fill_and_burst(5, stall, 1'b0, -1, aborted);
        @(negedge clk);
        chk("compute.startCompute", startCompute, 1);
        chk("compute.startInput", startInput, 0);
        chk("compute.getResult", getResult, 0);
        chk("compute.in_ready", hif.in_ready, 0);
        repeat (498) @(negedge clk);
        chk("compute_hold.startCompute", startCompute, 1);
    endtask

    task automatic apply_tbl(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            exp_state = tbl[i].es;
            res_out   = tbl[i].ro;
            @(negedge clk);
            chk($sformatf("row%0d.startCompute", i), startCompute, tbl[i].sc);
            chk($sformatf("row%0d.getResult", i), getResult, tbl[i].gr);
            chk($sformatf("row%0d.res_valid", i), hif.res_valid, tbl[i].rv);
            chk($sformatf("row%0d.res_last", i), hif.res_last, tbl[i].rl);
            chk($sformatf("row%0d.busy", i), busy, tbl[i].bz);
            chk($sformatf("row%0d.in_ready", i), hif.in_ready, tbl[i].rdy);
            if (tbl[i].rv) chk($sformatf("row%0d.res_data", i), hif.res_data, tbl[i].ro);
        end
        exp_state = 5'd0;
        res_out   = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        bit ab;
        // Full result handoff: stray 14 in COMPUTE, then 13, 32 words, 15.
        add_row(5'd14, 128'd99, 1, 0, 0, 0, 1, 0);
        add_row(5'd13, 128'd0,  0, 1, 0, 0, 1, 0);
        for (int i = 0; i < WORDS; i++)
            add_row(5'd14, 128'(i), 0, 1, 1, (i == WORDS - 1), 1, 0);
        add_row(5'd0,  128'd0, 0, 1, 0, 0, 1, 0);
        add_row(5'd15, 128'd0, 0, 0, 0, 0, 1, 0);
        add_row(5'd0,  128'd0, 0, 0, 0, 0, 0, 1);
        full_hi = tbl.size();
        // Early finish after 5 words: no res_last.
        add_row(5'd13, 128'd0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            add_row(5'd14, 128'h100 + 128'(i), 0, 1, 1, 0, 1, 0);
        add_row(5'd15, 128'd0, 0, 0, 0, 0, 1, 0);
        add_row(5'd0,  128'd0, 0, 0, 0, 0, 0, 1);

        reset        = 1'b1;
        hif.in_valid = 1'b0;
        hif.in_data  = '0;
        exp_state    = 5'd0;
        res_out      = '0;
        clear_held();
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("idle");

        run_job(1'b0, 1'b1, -1, -1, ab);
        apply_tbl(0, full_hi);

        run_job(1'b1, 1'b0, -1, -1, ab);
        apply_tbl(full_hi, tbl.size());

        run_job(1'b0, 1'b0, 1, 10, ab);
        chk("abort_reached", ab, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("mid_burst_reset");
        reset = 1'b0;
        clear_held();

        run_job(1'b0, 1'b0, -1, -1, ab);
        apply_tbl(0, full_hi);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
